// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request per handshake, word-aligned byte-enabled memory port, one-cycle response.
// Latency: 2 cycles minimum (accept -> mem_req -> rsp); the core is held off with req_ready low until the response.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lane;
    } ctx_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    ctx_t          ctx_q, ctx_d;

    logic        rsp_valid_d, rsp_err_d, mem_req_d, mem_we_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_be_d;

    logic        req_legal, req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign req_ready = (state_q == IDLE);

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        req_legal      = req_we ? (req_funct3 <= 3'b010)
                                : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    req_be         = 4'b0001 << req_addr[1:0];
                    req_lane_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                    req_lane_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    req_be         = 4'b1111;
                    req_lane_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load data extraction from the returned word.
    always_comb begin
        case (ctx_q.lane)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ctx_q.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ctx_q.funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctx_d       = ctx_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ctx_d = '{funct3: req_funct3, lane: req_addr[1:0]};
                    cnt_d = '0;
                    if (!req_legal || req_misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_lane_wdata;
                    end
                end
            end
            ACCESS: begin
                // An ack arriving on the expiry cycle still completes the access cleanly.
                if (mem_ack || ((TIMEOUT != 0) && (cnt_q == TLIM))) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !mem_ack;
                    rsp_rdata_d = (mem_ack && !mem_we) ? ld_data : 32'h0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'h0;
                    mem_wdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctx_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctx_q     <= ctx_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule
